// File: rtl/oled_serial_responder.sv
// rtl/oled_serial_responder.sv - SSD1306-style write-only 2-wire target
// Decodes control/command/data bytes into command strobes and framebuffer writes.
module oled_serial_responder #(
  parameter int         SERIAL_BITS   = 8,
  parameter int         SCREEN_WIDTH  = 128,
  parameter int         SCREEN_HEIGHT = 64,
  parameter int         SCREEN_PAGES  = SCREEN_HEIGHT / SERIAL_BITS,
  parameter logic [6:0] DEV_ADDR      = 7'h3c,
  parameter int         HCTR_BITS     = $clog2(SCREEN_WIDTH),
  parameter int         PAGE_BITS     = $clog2(SCREEN_PAGES)
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_serial_clk,
  inout  wire                  inout_serial,
  output logic                 out_pix_we,
  output logic [HCTR_BITS-1:0] out_pix_x,
  output logic [PAGE_BITS-1:0] out_pix_page,
  output logic [7:0]           out_pixels,
  output logic                 out_cmd_valid,
  output logic [7:0]           out_cmd,
  output logic                 out_cmd_arg,
  output logic                 out_display_on,
  output logic [7:0]           out_contrast,
  output logic                 out_busy,
  output logic                 out_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_CTRL, S_CTRL_ACK, S_BYTE, S_BYTE_ACK, S_IGNORE
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(SERIAL_BITS);

  state_t               state_q, state_d;
  logic [1:0]           scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic                 scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d, op_q, op_d;
  logic                 co_q, co_d, dc_q, dc_d, sda_oe_q, sda_oe_d;
  logic [1:0]           arg_cnt_q, arg_cnt_d;
  logic [HCTR_BITS-1:0] x_q, x_d, col_start_q, col_start_d, col_end_q, col_end_d, pix_x_q, pix_x_d;
  logic [PAGE_BITS-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
  logic [PAGE_BITS-1:0] pix_page_q, pix_page_d;
  logic [7:0]           pixels_q, pixels_d, cmd_q, cmd_d, contrast_q, contrast_d;
  logic                 pix_we_q, pix_we_d, cmd_valid_q, cmd_valid_d, cmd_arg_q, cmd_arg_d;
  logic                 display_on_q, display_on_d, busy_q, busy_d, error_q, error_d;

  logic       scl, sda, scl_rise, scl_fall, start_c, stop_c, byte_done;
  logic [7:0] byte_full;

  assign inout_serial = sda_oe_q ? 1'b0 : 1'bz;

  always_comb begin
    scl_sync_d   = {scl_sync_q[0], in_serial_clk};
    sda_sync_d   = {sda_sync_q[0], inout_serial};
    scl          = scl_sync_q[1];
    sda          = sda_sync_q[1];
    scl_prev_d   = scl;
    sda_prev_d   = sda;
    scl_rise     = scl & ~scl_prev_q;
    scl_fall     = ~scl & scl_prev_q;
    start_c      = scl & scl_prev_q & sda_prev_q & ~sda;
    stop_c       = scl & scl_prev_q & ~sda_prev_q & sda;
    byte_full    = {shift_q[6:0], sda};
    byte_done    = 1'b0;

    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    op_d         = op_q;
    co_d         = co_q;
    dc_d         = dc_q;
    arg_cnt_d    = arg_cnt_q;
    x_d          = x_q;
    page_d       = page_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    pix_we_d     = 1'b0;
    pix_x_d      = pix_x_q;
    pix_page_d   = pix_page_q;
    pixels_d     = pixels_q;
    cmd_valid_d  = 1'b0;
    cmd_d        = cmd_q;
    cmd_arg_d    = cmd_arg_q;
    display_on_d = display_on_q;
    contrast_d   = contrast_q;
    busy_d       = busy_q;
    error_d      = error_q;

    if (start_c) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      arg_cnt_d = '0;
    end else if (stop_c) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      arg_cnt_d = '0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_CTRL, S_BYTE: begin
          if (bit_cnt_q != LAST_BIT) begin
            if (scl_rise) begin
              shift_d   = byte_full;
              bit_cnt_d = bit_cnt_q + 4'd1;
              byte_done = (bit_cnt_q == LAST_BIT - 4'd1);
            end
          end else if (scl_fall) begin
            bit_cnt_d = '0;
            if (state_q == S_ADDR) begin
              state_d = S_ADDR_ACK;
              busy_d  = 1'b1;
            end else if (state_q == S_CTRL) begin
              state_d = S_CTRL_ACK;
            end else begin
              state_d = S_BYTE_ACK;
            end
          end
        end
        // bit_cnt marks that the 9th SCL rise has been seen before release
        S_ADDR_ACK, S_CTRL_ACK, S_BYTE_ACK: begin
          if (scl_rise) begin
            bit_cnt_d = 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            bit_cnt_d = '0;
            if (state_q == S_BYTE_ACK && !co_q) state_d = S_BYTE;
            else if (state_q == S_BYTE_ACK)    state_d = S_CTRL;
            else if (state_q == S_CTRL_ACK)    state_d = S_BYTE;
            else                               state_d = S_CTRL;
          end
        end
        default: ;
      endcase
    end

    if (byte_done) begin
      case (state_q)
        S_ADDR: begin
          if (byte_full[7:1] != DEV_ADDR) begin
            state_d = S_IGNORE;
          end else if (byte_full[0]) begin
            state_d = S_IGNORE;
            error_d = 1'b1;
          end
        end
        S_CTRL: begin
          co_d = byte_full[7];
          dc_d = byte_full[6];
        end
        default: begin
          if (dc_q) begin
            pix_we_d   = 1'b1;
            pix_x_d    = x_q;
            pix_page_d = page_q;
            pixels_d   = byte_full;
            if (x_q == col_end_q) begin
              x_d    = col_start_q;
              page_d = (page_q == page_end_q) ? page_start_q : page_q + PAGE_BITS'(1);
            end else begin
              x_d = x_q + HCTR_BITS'(1);
            end
          end else begin
            cmd_valid_d = 1'b1;
            cmd_d       = byte_full;
            if (arg_cnt_q != 2'd0) begin
              cmd_arg_d = 1'b1;
              arg_cnt_d = arg_cnt_q - 2'd1;
              case (op_q)
                8'h81: contrast_d = byte_full;
                8'h21: begin
                  if (arg_cnt_q == 2'd2) col_start_d = byte_full[HCTR_BITS-1:0];
                  else begin
                    col_end_d = byte_full[HCTR_BITS-1:0];
                    x_d       = col_start_q;
                  end
                end
                8'h22: begin
                  if (arg_cnt_q == 2'd2) page_start_d = byte_full[PAGE_BITS-1:0];
                  else begin
                    page_end_d = byte_full[PAGE_BITS-1:0];
                    page_d     = page_start_q;
                  end
                end
                default: ;
              endcase
            end else begin
              cmd_arg_d = 1'b0;
              op_d      = byte_full;
              case (byte_full)
                8'h21, 8'h22: arg_cnt_d = 2'd2;
                8'h20, 8'h81, 8'h8d, 8'ha8, 8'hd3,
                8'hd5, 8'hd9, 8'hda, 8'hdb: arg_cnt_d = 2'd1;
                8'hae: display_on_d = 1'b0;
                8'haf: display_on_d = 1'b1;
                default: ;
              endcase
            end
          end
        end
      endcase
    end

    sda_oe_d = (state_d == S_ADDR_ACK) || (state_d == S_CTRL_ACK) || (state_d == S_BYTE_ACK);
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q      <= S_IDLE;
      scl_sync_q   <= 2'b11;
      sda_sync_q   <= 2'b11;
      scl_prev_q   <= 1'b1;
      sda_prev_q   <= 1'b1;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      op_q         <= '0;
      co_q         <= 1'b0;
      dc_q         <= 1'b0;
      sda_oe_q     <= 1'b0;
      arg_cnt_q    <= '0;
      x_q          <= '0;
      page_q       <= '0;
      col_start_q  <= '0;
      col_end_q    <= HCTR_BITS'(SCREEN_WIDTH - 1);
      page_start_q <= '0;
      page_end_q   <= PAGE_BITS'(SCREEN_PAGES - 1);
      pix_we_q     <= 1'b0;
      pix_x_q      <= '0;
      pix_page_q   <= '0;
      pixels_q     <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_q        <= '0;
      cmd_arg_q    <= 1'b0;
      display_on_q <= 1'b0;
      contrast_q   <= 8'h7f;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      scl_sync_q   <= scl_sync_d;
      sda_sync_q   <= sda_sync_d;
      scl_prev_q   <= scl_prev_d;
      sda_prev_q   <= sda_prev_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      op_q         <= op_d;
      co_q         <= co_d;
      dc_q         <= dc_d;
      sda_oe_q     <= sda_oe_d;
      arg_cnt_q    <= arg_cnt_d;
      x_q          <= x_d;
      page_q       <= page_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      pix_we_q     <= pix_we_d;
      pix_x_q      <= pix_x_d;
      pix_page_q   <= pix_page_d;
      pixels_q     <= pixels_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_q        <= cmd_d;
      cmd_arg_q    <= cmd_arg_d;
      display_on_q <= display_on_d;
      contrast_q   <= contrast_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
    end
  end

  assign out_pix_we     = pix_we_q;
  assign out_pix_x      = pix_x_q;
  assign out_pix_page   = pix_page_q;
  assign out_pixels     = pixels_q;
  assign out_cmd_valid  = cmd_valid_q;
  assign out_cmd        = cmd_q;
  assign out_cmd_arg    = cmd_arg_q;
  assign out_display_on = display_on_q;
  assign out_contrast   = contrast_q;
  assign out_busy       = busy_q;
  assign out_error      = error_q;

endmodule

// File: tb/tb_oled_serial_responder.sv
// tb/tb_oled_serial_responder.sv - bit-banged bus master with reference model
// Checks acks, command strobes, framebuffer addressing and abort handling.
module tb_oled_serial_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_low = 1'b0;
  wire        sda;
  logic       out_pix_we, out_cmd_valid, out_cmd_arg, out_display_on, out_busy, out_error;
  logic [6:0] out_pix_x;
  logic [2:0] out_pix_page;
  logic [7:0] out_pixels, out_cmd, out_contrast;

  pullup (sda);
  assign sda = sda_low ? 1'b0 : 1'bz;

  oled_serial_responder dut (
    .in_clk(clk), .in_rst(rst), .in_serial_clk(scl), .inout_serial(sda),
    .out_pix_we(out_pix_we), .out_pix_x(out_pix_x), .out_pix_page(out_pix_page),
    .out_pixels(out_pixels), .out_cmd_valid(out_cmd_valid), .out_cmd(out_cmd),
    .out_cmd_arg(out_cmd_arg), .out_display_on(out_display_on), .out_contrast(out_contrast),
    .out_busy(out_busy), .out_error(out_error)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          q_clk = 4;
  int          m_pending = 0;
  logic [17:0] pix_q[$];
  logic [8:0]  cmd_q[$];
  bit          dut_drove = 1'b0;

  always @(negedge clk) begin
    if (out_pix_we)    pix_q.push_back({out_pix_page, out_pix_x, out_pixels});
    if (out_cmd_valid) cmd_q.push_back({out_cmd_arg, out_cmd});
  end

  always @(posedge clk) begin
    if (!sda_low && sda === 1'b0) dut_drove = 1'b1;
  end

  function automatic int n_args(input logic [7:0] op);
    case (op)
      8'h21, 8'h22: return 2;
      8'h20, 8'h81, 8'h8d, 8'ha8, 8'hd3, 8'hd5, 8'hd9, 8'hda, 8'hdb: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [8:0] model_cmd(input logic [7:0] b);
    if (m_pending > 0) begin
      m_pending--;
      return {1'b1, b};
    end
    m_pending = n_args(b);
    return {1'b0, b};
  endfunction

  // Horizontal addressing as a linear walk through the column/page window.
  function automatic logic [17:0] model_pix(input int idx, input int cs, input int ce,
                                            input int ps, input int pe, input logic [7:0] b);
    int w, h, x, p;
    w = ce - cs + 1;
    h = pe - ps + 1;
    x = cs + idx % w;
    p = ps + (idx / w) % h;
    return {3'(p), 7'(x), b};
  endfunction

  task automatic wait_q();
    repeat (q_clk) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_low = 1'b0; wait_q();
    scl = 1'b1;     wait_q();
    sda_low = 1'b1; wait_q();
    scl = 1'b0;     wait_q();
    m_pending = 0;
  endtask

  task automatic bus_stop();
    sda_low = 1'b1; wait_q();
    scl = 1'b1;     wait_q();
    sda_low = 1'b0; wait_q(); wait_q();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sda_low = ~b[7-i]; wait_q();
      scl = 1'b1;        wait_q(); wait_q();
      scl = 1'b0;        wait_q();
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    sda_low = 1'b0; wait_q();
    scl = 1'b1;     wait_q();
    ack = (sda === 1'b0);
    wait_q();
    scl = 1'b0;     wait_q();
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (out_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", out_busy); end
    n_checks++; if (out_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", out_error); end
    n_checks++; if (out_display_on !== 1'b0) begin n_fail++; $display("FAIL reset_display: got %b want 0", out_display_on); end
    n_checks++; if (out_contrast !== 8'h7f) begin n_fail++; $display("FAIL reset_contrast: got %h want 7f", out_contrast); end
    n_checks++; if ({out_pix_we, out_cmd_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b want 00", {out_pix_we, out_cmd_valid}); end
    n_checks++; if (sda !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b want 1", sda); end
  endtask

  task automatic test_display_on();
    logic a0, a1, a2;
    logic [8:0] exp;
    cmd_q.delete();
    bus_start();
    write_byte(8'h78, a0);
    n_checks++; if (out_busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_addr: got %b want 1", out_busy); end
    write_byte(8'h80, a1);
    write_byte(8'hAF, a2);
    exp = model_cmd(8'hAF);
    bus_stop();
    n_checks++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL disp_acks: got %b want 111", {a0, a1, a2}); end
    n_checks++; if (cmd_q.size() != 1) begin n_fail++; $display("FAIL disp_cmd_count: got %0d want 1", cmd_q.size()); end
    else begin
      n_checks++; if (cmd_q[0] !== exp) begin n_fail++; $display("FAIL disp_cmd: got %h want %h", cmd_q[0], exp); end
    end
    n_checks++; if (out_display_on !== 1'b1) begin n_fail++; $display("FAIL display_on: got %b want 1", out_display_on); end
    n_checks++; if (out_busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_stop: got %b want 0", out_busy); end
    n_checks++; if (sda !== 1'b1) begin n_fail++; $display("FAIL disp_sda_released: got %b want 1", sda); end
  endtask

  task automatic test_cmd_args();
    logic [7:0] seq[4] = '{8'h81, 8'h3C, 8'hD5, 8'hF0};
    logic [8:0] exp[$];
    logic a, all_ack;
    cmd_q.delete();
    bus_start();
    write_byte(8'h78, all_ack);
    write_byte(8'h00, a); all_ack &= a;
    foreach (seq[i]) begin
      write_byte(seq[i], a); all_ack &= a;
      exp.push_back(model_cmd(seq[i]));
    end
    bus_stop();
    n_checks++; if (all_ack !== 1'b1) begin n_fail++; $display("FAIL args_acks: got %b want 1", all_ack); end
    n_checks++; if (cmd_q.size() != exp.size()) begin n_fail++; $display("FAIL args_count: got %0d want %0d", cmd_q.size(), exp.size()); end
    else foreach (exp[i]) begin
      n_checks++; if (cmd_q[i] !== exp[i]) begin n_fail++; $display("FAIL args_cmd[%0d]: got %h want %h", i, cmd_q[i], exp[i]); end
    end
    n_checks++; if (out_contrast !== 8'h3C) begin n_fail++; $display("FAIL contrast: got %h want 3c", out_contrast); end
  endtask

  task automatic test_full_frame();
    logic a;
    int   nacks = 0;
    logic [17:0] exp;
    pix_q.delete();
    q_clk = 2;
    bus_start();
    write_byte(8'h78, a); if (!a) nacks++;
    write_byte(8'h40, a); if (!a) nacks++;
    for (int i = 0; i < 1025; i++) begin
      write_byte(8'(i), a); if (!a) nacks++;
    end
    bus_stop();
    q_clk = 4;
    n_checks++; if (nacks != 0) begin n_fail++; $display("FAIL frame_acks: got %0d nacks want 0", nacks); end
    n_checks++; if (pix_q.size() != 1025) begin n_fail++; $display("FAIL frame_count: got %0d want 1025", pix_q.size()); end
    else for (int i = 0; i < 1025; i++) begin
      exp = model_pix(i, 0, 127, 0, 7, 8'(i));
      n_checks++; if (pix_q[i] !== exp) begin n_fail++; $display("FAIL frame_pix[%0d]: got %h want %h", i, pix_q[i], exp); end
    end
  endtask

  task automatic test_window(input int cs, input int ce, input int ps, input int pe, input int n);
    logic [7:0] cmds[6];
    logic [7:0] data[$];
    logic [8:0] exp_cmd[$];
    logic [17:0] exp;
    logic a, all_ack;
    cmds = '{8'h21, 8'(cs), 8'(ce), 8'h22, 8'(ps), 8'(pe)};
    pix_q.delete();
    cmd_q.delete();
    bus_start();
    write_byte(8'h78, all_ack);
    foreach (cmds[i]) begin
      write_byte(8'h80, a); all_ack &= a;
      write_byte(cmds[i], a); all_ack &= a;
      exp_cmd.push_back(model_cmd(cmds[i]));
    end
    write_byte(8'h40, a); all_ack &= a;
    for (int i = 0; i < n; i++) begin
      data.push_back(8'($urandom));
      write_byte(data[i], a); all_ack &= a;
    end
    bus_stop();
    n_checks++; if (all_ack !== 1'b1) begin n_fail++; $display("FAIL win_acks: got %b want 1", all_ack); end
    n_checks++; if (cmd_q.size() != 6) begin n_fail++; $display("FAIL win_cmd_count: got %0d want 6", cmd_q.size()); end
    else foreach (exp_cmd[i]) begin
      n_checks++; if (cmd_q[i] !== exp_cmd[i]) begin n_fail++; $display("FAIL win_cmd[%0d]: got %h want %h", i, cmd_q[i], exp_cmd[i]); end
    end
    n_checks++; if (pix_q.size() != n) begin n_fail++; $display("FAIL win_count: got %0d want %0d", pix_q.size(), n); end
    else for (int i = 0; i < n; i++) begin
      exp = model_pix(i, cs, ce, ps, pe, data[i]);
      n_checks++; if (pix_q[i] !== exp) begin n_fail++; $display("FAIL win_pix[%0d]: got %h want %h", i, pix_q[i], exp); end
    end
  endtask

  task automatic test_random_windows();
    for (int k = 0; k < 3; k++) begin
      int cs, ce, ps, pe;
      cs = $urandom_range(0, 127);
      ce = $urandom_range(cs, 127);
      ps = $urandom_range(0, 7);
      pe = $urandom_range(ps, 7);
      test_window(cs, ce, ps, pe, $urandom_range(5, 30));
    end
  endtask

  task automatic test_bad_addr(input logic [7:0] addr, input logic want_err);
    logic a0, a1;
    pix_q.delete();
    cmd_q.delete();
    dut_drove = 1'b0;
    bus_start();
    write_byte(addr, a0);
    write_byte(8'h80, a1);
    bus_stop();
    n_checks++; if ({a0, a1} !== 2'b00) begin n_fail++; $display("FAIL bad_%h_acks: got %b want 00", addr, {a0, a1}); end
    n_checks++; if (dut_drove !== 1'b0) begin n_fail++; $display("FAIL bad_%h_sda_driven: got %b want 0", addr, dut_drove); end
    n_checks++; if (pix_q.size() + cmd_q.size() != 0) begin n_fail++; $display("FAIL bad_%h_strobes: got %0d want 0", addr, pix_q.size() + cmd_q.size()); end
    n_checks++; if (out_error !== want_err) begin n_fail++; $display("FAIL bad_%h_error: got %b want %b", addr, out_error, want_err); end
    n_checks++; if (out_busy !== 1'b0) begin n_fail++; $display("FAIL bad_%h_busy: got %b want 0", addr, out_busy); end
  endtask

  task automatic test_stop_mid_byte();
    logic a0, a1, a2;
    pix_q.delete();
    cmd_q.delete();
    bus_start();
    write_byte(8'h78, a0);
    write_byte(8'h40, a1);
    send_bits(8'hC3, 4);
    bus_stop();
    n_checks++; if (pix_q.size() != 0) begin n_fail++; $display("FAIL stop_mid_strobe: got %0d want 0", pix_q.size()); end
    n_checks++; if (sda !== 1'b1 || out_busy !== 1'b0) begin n_fail++; $display("FAIL stop_mid_bus: got sda=%b busy=%b want 1 0", sda, out_busy); end
    bus_start();
    write_byte(8'h78, a0);
    write_byte(8'h80, a1);
    write_byte(8'hAE, a2);
    bus_stop();
    n_checks++; if (cmd_q.size() != 1 || cmd_q[0] !== 9'h0AE) begin n_fail++; $display("FAIL stop_mid_next_cmd: got n=%0d want one 0ae", cmd_q.size()); end
    n_checks++; if (out_display_on !== 1'b0) begin n_fail++; $display("FAIL display_off: got %b want 0", out_display_on); end
  endtask

  task automatic test_reset_mid_byte();
    logic a0, a1, a2;
    bus_start();
    write_byte(8'h78, a0);
    write_byte(8'h40, a1);
    pix_q.delete();
    send_bits(8'hA5, 4);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus_stop();
    n_checks++; if (pix_q.size() != 0) begin n_fail++; $display("FAIL rst_mid_strobe: got %0d want 0", pix_q.size()); end
    n_checks++; if (sda !== 1'b1) begin n_fail++; $display("FAIL rst_mid_sda: got %b want 1", sda); end
    n_checks++; if (out_error !== 1'b0 || out_contrast !== 8'h7f) begin n_fail++; $display("FAIL rst_mid_regs: got err=%b contrast=%h want 0 7f", out_error, out_contrast); end
    bus_start();
    write_byte(8'h78, a0);
    write_byte(8'h40, a1);
    write_byte(8'h5A, a2);
    bus_stop();
    n_checks++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL rst_mid_acks: got %b want 111", {a0, a1, a2}); end
    n_checks++; if (pix_q.size() != 1 || pix_q[0] !== model_pix(0, 0, 127, 0, 7, 8'h5A)) begin
      n_fail++; $display("FAIL rst_mid_next_pix: got n=%0d want one write of 5a at (0,0)", pix_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_display_on();
    test_cmd_args();
    test_full_frame();
    test_window(10, 11, 2, 3, 5);
    test_random_windows();
    test_bad_addr(8'h7A, 1'b0);
    test_bad_addr(8'h79, 1'b1);
    test_stop_mid_byte();
    test_reset_mid_byte();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/oled_serial_responder.md
Name: oled_serial_responder

Overview:
- 2-wire (I2C-style) write-only target that emulates the SSD1306 receive side.
- Samples SCL/SDA, matches the 7-bit device address, ACKs bytes, and splits control/command/data bytes per SSD1306 framing.
- Data bytes go to a page-organised framebuffer write port using horizontal addressing; a subset of commands is decoded.
- Used as the bus partner of the display master in simulation and in loop-back FPGA tests.

Parameters:
- SERIAL_BITS, 8, bits per byte (fixed framing; only 8 supported)
- SCREEN_WIDTH, 128, columns
- SCREEN_HEIGHT, 64, pixel rows
- SCREEN_PAGES, SCREEN_HEIGHT / SERIAL_BITS, pages
- DEV_ADDR, 7'h3c, 7-bit target address
- HCTR_BITS, $clog2(SCREEN_WIDTH), column counter width
- PAGE_BITS, $clog2(SCREEN_PAGES), page counter width

Ports:
- in_clk  in  1  system clock; must be at least 8x SCL
- in_rst  in  1  synchronous reset, active-high
- in_serial_clk  in  1  SCL; never driven, no clock stretching
- inout_serial  inout  1  SDA, open-drain: drives 1'b0 or 1'bz only
- out_pix_we  out  1  one-cycle framebuffer write strobe
- out_pix_x  out  HCTR_BITS  column of the write
- out_pix_page  out  PAGE_BITS  page of the write
- out_pixels  out  8  pixel byte (bit0 = top row of page)
- out_cmd_valid  out  1  one-cycle strobe per received command or argument byte
- out_cmd  out  8  the received command or argument byte
- out_cmd_arg  out  1  1 = out_cmd is an argument byte
- out_display_on  out  1  display state (0xAE = off, 0xAF = on)
- out_contrast  out  8  last argument of 0x81
- out_busy  out  1  1 from an address match until STOP
- out_error  out  1  sticky; set on read request (R/W=1); cleared by reset

Behaviour:
- Input sampling:
  - SCL and SDA each pass a 2-FF synchroniser, then a registered edge detector.
  - All events below refer to the synchronised signals.
- Bus conditions:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Data bits are sampled on the SCL rising edge, MSB first.
- States: Idle, Addr, AddrAck, Ctrl, CtrlAck, Byte, ByteAck, Ignore.
  - Idle: on START, go to Addr.
  - Addr: collect 8 bits.
    - Bits[7:1]==DEV_ADDR and bit0==0: go to AddrAck.
    - Address match with bit0==1: set out_error, go to Ignore.
    - Address mismatch: go to Ignore.
  - AddrAck: drive SDA low from the SCL falling edge after bit 8 until the SCL falling edge after the 9th clock; set out_busy; go to Ctrl.
  - Ctrl: collect the control byte, then go to CtrlAck. Latch Co=bit7 and DC=bit6.
  - CtrlAck: ACK as above, then go to Byte.
  - Byte: collect one byte. One cycle after the 8th-bit SCL rising edge, assert out_pix_we (DC=1) or out_cmd_valid (DC=0) for exactly 1 clock. Then go to ByteAck.
  - ByteAck: ACK. If Co=1, go to Ctrl; if Co=0, go to Byte.
  - Ignore: SDA stays released, no strobes, until STOP or START.
- STOP in any state: go to Idle, release SDA, clear out_busy. A partial byte is discarded with no strobe.
- START (repeated START) in any non-Idle state: go to Addr; the partial byte is discarded.
- Command decoding (DC=0):
  - An argument counter persists across control bytes within one transaction and is cleared at STOP/START.
  - A byte received while the counter is >0 is an argument: out_cmd_arg=1, counter decrements.
  - Otherwise the byte is an opcode (out_cmd_arg=0) and loads the counter:
    - 2 arguments: 0x21, 0x22
    - 1 argument: 0x20, 0x81, 0x8d, 0xa8, 0xd3, 0xd5, 0xd9, 0xda, 0xdb
    - 0 arguments: all others
  - 0xAE / 0xAF: out_display_on <= 0 / 1.
  - 0x81 argument: loads out_contrast.
  - 0x21 arguments: col_start, then col_end (truncated to HCTR_BITS); second argument also sets x = col_start.
  - 0x22 arguments: page_start, then page_end (truncated to PAGE_BITS); second argument also sets page = page_start.
  - All other commands only strobe out_cmd.
- Data addressing (DC=1):
  - The write uses the current x and page.
  - If x==col_end: x = col_start and the page advances. If page==page_end, page wraps to page_start; otherwise page increments.
  - Otherwise x increments.
  - out_pix_x and out_pix_page show the pre-increment address during the out_pix_we cycle.
- Reset values:
  - State Idle, SDA released (z).
  - All strobes 0; out_busy=0; out_error=0; out_display_on=0; out_contrast=8'h7f.
  - x=0, page=0, col_start=0, col_end=SCREEN_WIDTH-1, page_start=0, page_end=SCREEN_PAGES-1.
  - Reset mid-transfer leaves the bus released and waits for the next START.

Test Plan:
- START, 0x78, 0x80, 0xAF, STOP → 2 ACKs plus command ACK; out_cmd_valid once with out_cmd=0xAF, out_cmd_arg=0; out_display_on=1.
- START, 0x78, 0x00, 0x81, 0x3C, 0xD5, 0xF0, STOP → 4 cmd strobes with out_cmd_arg pattern 0,1,0,1; out_contrast=0x3C.
- START, 0x78, 0x40, then 1025 bytes i[7:0] → writes at (0,0)…(127,0), (0,1)…(127,7); the 1025th byte wraps to (0,0) with value 0x00.
- 0x21, 10, 11 and 0x22, 2, 3, then data A,B,C,D,E → writes at (10,2), (11,2), (10,3), (11,3), (10,2).
- Address 0x7A (mismatch) or 0x79 (read) → SDA never driven, no strobes; out_error=1 only for 0x79.
- STOP after 4 data bits, and separately in_rst mid-byte → no strobe; SDA=z; next valid transaction works normally.
